pwr_bus_engine: RTL and testbench



---
 rtl/pwr_bus_engine.sv | 135 +++++++++++++
 tb/tb_pwr_bus_engine.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pwr_bus_engine.sv
// pwr_bus_engine: Avalon-MM slave that times power-bus write/read strobes in hardware.
module pwr_bus_engine #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  inout  wire  [7:0]  pwr_data,
  output logic        pwr_wr_n,
  output logic        pwr_rd_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [7:0] r_tx_byte, r_rx_data;
  logic r_rx_valid, r_ovf, r_enable, r_pend, r_oe;
  logic w_wr, w_rd0, w_wr3, w_empty, w_full, w_flush, w_push_req, w_push, w_pop;
  logic w_rdreq, w_rd_ok, w_start_rd, w_sample, w_busy, w_unused;
  logic [31:0] w_stat;
  assign w_wr       = chipselect & ~write_n;
  assign w_rd0      = chipselect & write_n & (address == 2'd0);
  assign w_wr3      = w_wr & (address == 2'd3);
  assign w_empty    = r_level == '0;
  assign w_full     = r_level == LW'(FIFO_DEPTH);
  assign w_flush    = w_wr3 & writedata[2];
  assign w_push_req = w_wr & (address == 2'd0);
  assign w_push     = w_push_req & ~w_full & ~w_flush;
  assign w_pop      = (r_state == IDLE) & r_enable & ~w_empty & ~w_flush;
  assign w_rdreq    = w_wr & (address == 2'd2);
  assign w_rd_ok    = w_empty & ~r_pend;
  assign w_start_rd = (r_state == IDLE) & ~w_pop & r_enable & r_pend;
  assign w_busy     = r_state != IDLE;
  assign w_stat     = 32'({r_level, 3'b000, r_ovf, r_rx_valid, w_empty, w_full, w_busy});
  assign w_unused   = ^writedata[31:8];
  assign pwr_data   = r_oe ? r_tx_byte : 8'hzz;
  // FIFO storage; a flush only moves pointers, so the array needs no reset
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= writedata[7:0];
  // FIFO pointers and fill level; flush discards everything queued
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  // next-state and phase counter: counter is loaded with N-1 on entry so each phase lasts N clocks
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt - 8'd1;
    w_sample  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = 8'(SETUP_CYC - 1);
        w_next    = w_pop ? W_SETUP : w_start_rd ? R_SETUP : IDLE;
      end
      W_SETUP: if (r_cnt == 8'd0) begin
        w_next    = W_STROBE;
        w_cnt_nxt = 8'(STROBE_CYC - 1);
      end
      W_STROBE: if (r_cnt == 8'd0) begin
        w_next    = W_HOLD;
        w_cnt_nxt = 8'(HOLD_CYC - 1);
      end
      W_HOLD: w_next = (r_cnt == 8'd0) ? IDLE : W_HOLD;
      R_SETUP: if (r_cnt == 8'd0) begin
        w_next    = R_STROBE;
        w_cnt_nxt = 8'(STROBE_CYC - 1);
      end
      R_STROBE: if (r_cnt == 8'd0) begin
        w_next    = R_HOLD;
        w_cnt_nxt = 8'(HOLD_CYC - 1);
        w_sample  = 1'b1;
      end
      R_HOLD: w_next = (r_cnt == 8'd0) ? IDLE : R_HOLD;
      default: w_next = IDLE;
    endcase
  end
  // state register; strobes and bus enable are decoded from the next state so they are glitch-free flops
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      pwr_wr_n <= 1'b1;
      pwr_rd_n <= 1'b1;
      r_oe     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nxt;
      pwr_wr_n <= w_next != W_STROBE;
      pwr_rd_n <= w_next != R_STROBE;
      r_oe     <= (w_next == W_SETUP) | (w_next == W_STROBE) | (w_next == W_HOLD);
    end
  // control/status registers, captured read byte and registered readback mux
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_tx_byte  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_enable   <= 1'b0;
      r_pend     <= 1'b0;
      readdata   <= '0;
    end else begin
      r_tx_byte  <= w_pop ? r_mem[r_rptr] : r_tx_byte;
      r_rx_data  <= w_sample ? pwr_data : r_rx_data;
      r_rx_valid <= w_sample | (r_rx_valid & ~w_rd0);
      r_ovf      <= (w_wr3 & writedata[1]) ? 1'b0
                  : r_ovf | (w_push_req & w_full & ~w_flush) | (w_rdreq & ~w_rd_ok);
      r_enable   <= w_wr3 ? writedata[0] : r_enable;
      r_pend     <= w_flush ? 1'b0 : w_start_rd ? 1'b0 : (w_rdreq & w_rd_ok) ? 1'b1 : r_pend;
      readdata   <= (address == 2'd0) ? {24'd0, r_rx_data}
                  : (address == 2'd1) ? w_stat
                  : (address == 2'd3) ? {31'd0, r_enable} : 32'd0;
    end
endmodule

// File: tb/tb_pwr_bus_engine.sv
// tb_pwr_bus_engine: scoreboard bench for the power-bus strobe engine.
module tb_pwr_bus_engine;
  logic clk = 1'b0, reset_n = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic pwr_wr_n, pwr_rd_n;
  tri1 [7:0] pwr_data;
  logic [7:0] rx_drive = 8'h3C;
  logic rd_seen = 1'b0;
  int comps = 0, errs = 0, nwr = 0, nrd = 0, wcnt = 0, rcnt = 0;
  logic [31:0] exp_rd [$];
  logic [7:0] exp_wr [$];
  always #5 clk = ~clk;
  // peripheral model: answers a read strobe with rx_drive; otherwise the pull-up leaves 0xFF
  assign pwr_data = pwr_rd_n ? 8'hzz : rx_drive;
  pwr_bus_engine dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pwr_data(pwr_data), .pwr_wr_n(pwr_wr_n), .pwr_rd_n(pwr_rd_n)
  );
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1 chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    @(posedge clk);
    #1 chipselect = 1'b1; write_n = 1'b1; address = a; exp_rd.push_back(e);
    @(posedge clk);
    #1 chipselect = 1'b0;
  endtask
  always @(posedge clk) rd_seen <= chipselect & write_n;
  // monitor: pops expected strobe bytes and readback words as the DUT presents them
  always @(negedge clk) begin
    if (!reset_n) begin
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (!pwr_wr_n) begin
        if (wcnt == 0) begin
          nwr++;
          if (exp_wr.size() != 0) cmp("wr_data", {24'd0, pwr_data}, {24'd0, exp_wr.pop_front()});
          else cmp("wr_unexpected", {24'd0, pwr_data}, 32'h100);
        end
        wcnt++;
      end else if (wcnt != 0) begin
        cmp("wr_strobe_len", wcnt, 4);
        wcnt = 0;
      end
      if (!pwr_rd_n) begin
        if (rcnt == 0) nrd++;
        rcnt++;
        if (!pwr_wr_n) cmp("strobe_overlap", {31'd0, pwr_wr_n}, 32'd1);
      end else if (rcnt != 0) begin
        cmp("rd_strobe_len", rcnt, 4);
        rcnt = 0;
      end
      if (rd_seen) begin
        if (exp_rd.size() != 0) cmp("readdata", readdata, exp_rd.pop_front());
        else cmp("readdata_unexpected", readdata, 32'hDEADBEEF);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #1 reset_n = 1'b0;
    #1;
    cmp("rst_readdata", readdata, 0);
    cmp("rst_wr_n", {31'd0, pwr_wr_n}, 1);
    cmp("rst_rd_n", {31'd0, pwr_rd_n}, 1);
    cmp("rst_bus", {24'd0, pwr_data}, 32'hFF);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    rd(2'd1, 32'h004);
    rd(2'd3, 32'h000);
    rd(2'd0, 32'h000);
    // single write with exact phase timing
    wr(2'd3, 32'h1);
    exp_wr.push_back(8'hA5);
    wr(2'd0, 32'hA5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmp($sformatf("wr_bus_k%0d", k), {24'd0, pwr_data}, (k >= 1 && k <= 8) ? 32'hA5 : 32'hFF);
      cmp($sformatf("wr_n_k%0d", k), {31'd0, pwr_wr_n}, (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
    end
    rd(2'd1, 32'h004);
    // overflow: nine bytes into an eight-deep FIFO while disabled
    wr(2'd3, 32'h0);
    for (int i = 1; i <= 9; i++) wr(2'd0, i);
    rd(2'd1, 32'h812);
    for (int i = 1; i <= 8; i++) exp_wr.push_back(8'(i));
    wr(2'd3, 32'h1);
    repeat (100) @(negedge clk);
    rd(2'd1, 32'h014);
    wr(2'd3, 32'h3);
    rd(2'd1, 32'h004);
    // read transaction
    wr(2'd2, 32'h0);
    repeat (20) @(negedge clk);
    rd(2'd1, 32'h00C);
    rd(2'd0, 32'h03C);
    rd(2'd1, 32'h004);
    // read request refused while a byte is queued
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h77);
    wr(2'd2, 32'h0);
    rd(2'd1, 32'h110);
    exp_wr.push_back(8'h77);
    wr(2'd3, 32'h3);
    repeat (20) @(negedge clk);
    rd(2'd1, 32'h004);
    // reset during the write strobe
    exp_wr.push_back(8'h42);
    wr(2'd0, 32'h42);
    for (int i = 0; i < 30 && pwr_wr_n; i++) @(negedge clk);
    cmp("strobe_reached", {31'd0, pwr_wr_n}, 0);
    #1 reset_n = 1'b0;
    #1;
    cmp("midrst_wr_n", {31'd0, pwr_wr_n}, 1);
    cmp("midrst_bus", {24'd0, pwr_data}, 32'hFF);
    cmp("midrst_readdata", readdata, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (30) @(negedge clk);
    rd(2'd1, 32'h004);
    rd(2'd3, 32'h000);
    repeat (3) @(negedge clk);
    cmp("wr_strobe_count", nwr, 11);
    cmp("rd_strobe_count", nrd, 1);
    cmp("wr_queue_left", exp_wr.size(), 0);
    cmp("rd_queue_left", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end
endmodule
